// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic-analyzer sample RAM: circular write pointer,
// pre/armed/post-trigger phases, completion flag and readout address sequencing.
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              wrt_smpl,
  input  logic              triggered,
  input  logic              clr_done,
  input  logic              dump_start,
  input  logic              dump_nxt,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] raddr,
  output logic              armed,
  output logic              capture_done,
  output logic              dumping,
  output logic              dump_last
);

  localparam logic [ADDR_W:0]   DEPTH_V  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_CNT = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W:0]   r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_armed;
  logic              r_done;
  logic              r_dumping;
  logic              r_dump_last;

  logic              w_capturing;
  logic              w_we;
  logic [ADDR_W:0]   w_pre_target;
  logic [ADDR_W:0]   w_pre_cnt_inc;
  logic [ADDR_W-1:0] w_post_cnt_inc;
  logic [ADDR_W-1:0] w_rd_cnt_inc;

  assign w_capturing    = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_we           = wrt_smpl & w_capturing;
  // Pre-trigger quota is the part of the buffer not reserved for post-trigger samples.
  assign w_pre_target   = DEPTH_V - {1'b0, trig_pos};
  assign w_pre_cnt_inc  = r_pre_cnt + 1'b1;
  assign w_post_cnt_inc = r_post_cnt + 1'b1;
  assign w_rd_cnt_inc   = r_rd_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_rd_cnt    <= '0;
      r_armed     <= 1'b0;
      r_done      <= 1'b0;
      r_dumping   <= 1'b0;
      r_dump_last <= 1'b0;
    end else begin
      if (w_we) begin
        r_waddr <= r_waddr + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state   <= S_PRE;
            r_waddr   <= '0;
            r_pre_cnt <= '0;
          end
        end
        S_PRE: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else if (w_we) begin
            r_pre_cnt <= w_pre_cnt_inc;
            if (w_pre_cnt_inc == w_pre_target) begin
              r_state <= S_ARMED;
              r_armed <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (!run) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
          end else if (triggered) begin
            // A sample written in the trigger cycle belongs to the pre-trigger window.
            r_armed    <= 1'b0;
            r_post_cnt <= '0;
            if (trig_pos == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else if (w_we) begin
            r_post_cnt <= w_post_cnt_inc;
            if (w_post_cnt_inc == trig_pos) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (clr_done) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_dumping   <= 1'b0;
            r_dump_last <= 1'b0;
          end else if (r_dumping) begin
            if (dump_nxt) begin
              r_raddr <= r_raddr + 1'b1;
              if (r_dump_last) begin
                r_dumping   <= 1'b0;
                r_dump_last <= 1'b0;
                r_rd_cnt    <= '0;
              end else begin
                r_rd_cnt    <= w_rd_cnt_inc;
                r_dump_last <= (w_rd_cnt_inc == LAST_CNT);
              end
            end
          end else if (dump_start) begin
            // The frozen write pointer marks the oldest sample in the ring.
            r_dumping   <= 1'b1;
            r_raddr     <= r_waddr;
            r_rd_cnt    <= '0;
            r_dump_last <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign we           = w_we;
  assign waddr        = r_waddr;
  assign raddr        = r_raddr;
  assign armed        = r_armed;
  assign capture_done = r_done;
  assign dumping      = r_dumping;
  assign dump_last    = r_dump_last;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: a driver pushes reference-model expectations,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_capture_ctrl;

  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic          wrt_smpl = 1'b0;
  logic          triggered = 1'b0;
  logic          clr_done = 1'b0;
  logic          dump_start = 1'b0;
  logic          dump_nxt = 1'b0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic          armed;
  logic          capture_done;
  logic          dumping;
  logic          dump_last;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .run(run), .trig_pos(trig_pos), .wrt_smpl(wrt_smpl),
    .triggered(triggered), .clr_done(clr_done), .dump_start(dump_start),
    .dump_nxt(dump_nxt), .we(we), .waddr(waddr), .raddr(raddr), .armed(armed),
    .capture_done(capture_done), .dumping(dumping), .dump_last(dump_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int we; int waddr; int raddr; int armed; int done; int dumping; int last;
  } st_t;
  st_t st_q[$];
  int  wr_q[$];
  int  rd_q[$];

  int s_run = 0, s_wrt = 0, s_trig = 0, s_clr = 0, s_ds = 0, s_dn = 0, s_rst = 0, s_tp = 0;

  typedef enum int {M_IDLE, M_PRE, M_ARMED, M_POST, M_DONE} mph_t;
  mph_t m_ph = M_IDLE;
  int m_wa = 0, m_ra = 0, m_pre = 0, m_post = 0, m_rd = 0, m_dump = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_ph = M_IDLE; m_wa = 0; m_ra = 0; m_pre = 0; m_post = 0; m_rd = 0; m_dump = 0;
  endfunction

  function automatic void model_step(int w);
    if (m_ph == M_IDLE) begin
      if (s_run != 0) begin m_ph = M_PRE; m_wa = 0; m_pre = 0; end
    end else if (m_ph == M_DONE) begin
      if (s_clr != 0) begin
        m_ph = M_IDLE; m_dump = 0;
      end else if (m_dump != 0) begin
        if (s_dn != 0) begin
          m_ra = (m_ra + 1) % D;
          if (m_rd == D - 1) begin m_dump = 0; m_rd = 0; end
          else m_rd++;
        end
      end else if (s_ds != 0) begin
        m_dump = 1; m_ra = m_wa; m_rd = 0;
      end
    end else begin
      if (w != 0) m_wa = (m_wa + 1) % D;
      if (s_run == 0) m_ph = M_IDLE;
      else if (m_ph == M_PRE) begin
        if (w != 0) begin
          m_pre++;
          if (m_pre == D - s_tp) m_ph = M_ARMED;
        end
      end else if (m_ph == M_ARMED) begin
        if (s_trig != 0) begin
          m_post = 0;
          m_ph = (s_tp == 0) ? M_DONE : M_POST;
        end
      end else begin
        if (w != 0) begin
          m_post++;
          if (m_post == s_tp) m_ph = M_DONE;
        end
      end
    end
  endfunction

  task automatic tick();
    st_t e;
    @(posedge clk);
    #2;
    rst = 1'(s_rst); run = 1'(s_run); wrt_smpl = 1'(s_wrt); triggered = 1'(s_trig);
    clr_done = 1'(s_clr); dump_start = 1'(s_ds); dump_nxt = 1'(s_dn); trig_pos = AW'(s_tp);
    if (s_rst != 0) model_reset();
    e.we      = (s_wrt != 0 && s_rst == 0 &&
                 (m_ph == M_PRE || m_ph == M_ARMED || m_ph == M_POST)) ? 1 : 0;
    e.waddr   = m_wa;
    e.raddr   = m_ra;
    e.armed   = (m_ph == M_ARMED) ? 1 : 0;
    e.done    = (m_ph == M_DONE) ? 1 : 0;
    e.dumping = m_dump;
    e.last    = (m_dump != 0 && m_rd == D - 1) ? 1 : 0;
    st_q.push_back(e);
    if (e.we != 0) wr_q.push_back(m_wa);
    if (m_dump != 0) rd_q.push_back(m_ra * 2 + e.last);
    if (s_rst == 0) model_step(e.we);
    #1;
  endtask

  task automatic clear_pulses();
    s_wrt = 0; s_trig = 0; s_clr = 0; s_ds = 0; s_dn = 0; s_rst = 0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    st_t e;
    int  r;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("we", int'(we), e.we);
      chk("waddr", int'(waddr), e.waddr);
      chk("raddr", int'(raddr), e.raddr);
      chk("armed", int'(armed), e.armed);
      chk("capture_done", int'(capture_done), e.done);
      chk("dumping", int'(dumping), e.dumping);
      chk("dump_last", int'(dump_last), e.last);
    end
    if (we) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else chk("wr_addr", int'(waddr), wr_q.pop_front());
    end
    if (dumping) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        r = rd_q.pop_front();
        chk("rd_addr", int'(raddr), r / 2);
        chk("rd_last", int'(dump_last), r % 2);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_async_waddr", int'(waddr), 0);
    chk("rst_async_done", int'(capture_done), 0);
    chk("rst_async_we", int'(we), 0);
    s_rst = 1; tick(); s_rst = 0;

    // Basic capture: trig_pos=4, write every clock, trigger on the 20th write.
    s_tp = 4; s_run = 1; tick();
    s_wrt = 1;
    for (int i = 1; i <= 12; i++) tick();
    chk("t1_armed_before", int'(armed), 0);
    tick();
    chk("t1_armed_after12", int'(armed), 1);
    ticks(6);
    s_trig = 1; tick(); s_trig = 0;
    ticks(4);
    tick();
    chk("t1_done", int'(capture_done), 1);
    chk("t1_we_off", int'(we), 0);
    chk("t1_waddr", int'(waddr), 8);

    // Full dump from the oldest sample.
    s_wrt = 0; s_ds = 1; tick(); s_ds = 0;
    s_dn = 1;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("t2_raddr", int'(raddr), (8 + j) % 16);
      chk("t2_last", int'(dump_last), (j == 15) ? 1 : 0);
    end
    s_dn = 0; tick();
    chk("t2_dumping_end", int'(dumping), 0);
    chk("t2_raddr_end", int'(raddr), 8);

    // trig_pos=0: trigger in ARMED without a write completes immediately.
    s_clr = 1; tick(); s_clr = 0;
    s_tp = 0; tick();
    s_wrt = 1; ticks(16); s_wrt = 0;
    s_trig = 1; tick(); s_trig = 0;
    chk("t3_armed", int'(armed), 1);
    tick();
    chk("t3_done", int'(capture_done), 1);
    chk("t3_waddr", int'(waddr), 0);

    // Trigger held from run assertion is ignored during PRE.
    s_clr = 1; tick(); s_clr = 0;
    s_tp = 4; s_trig = 1; tick();
    s_wrt = 1; ticks(12);
    tick();
    chk("t4_armed", int'(armed), 1);
    tick();
    chk("t4_post_armed", int'(armed), 0);
    chk("t4_post_done", int'(capture_done), 0);
    ticks(3);
    tick();
    s_trig = 0;
    chk("t4_done", int'(capture_done), 1);
    chk("t4_waddr", int'(waddr), 1);

    // Abort in POST after two post-trigger writes, then restart.
    s_wrt = 0; s_clr = 1; tick(); s_clr = 0;
    tick();
    s_wrt = 1; ticks(19);
    s_trig = 1; tick(); s_trig = 0;
    ticks(2);
    s_run = 0; s_wrt = 0; tick();
    s_wrt = 1; tick();
    chk("t5_we_idle", int'(we), 0);
    chk("t5_armed", int'(armed), 0);
    chk("t5_done", int'(capture_done), 0);
    chk("t5_waddr_hold", int'(waddr), 6);
    s_run = 1; tick();
    tick();
    chk("t5_restart_waddr", int'(waddr), 0);
    chk("t5_restart_we", int'(we), 1);

    // Complete capture, dump three words, then reset mid-dump.
    ticks(18);
    s_trig = 1; tick(); s_trig = 0;
    ticks(4);
    s_wrt = 0; s_ds = 1; tick(); s_ds = 0;
    s_dn = 1; ticks(3); s_dn = 0;
    tick();
    chk("t6_raddr11", int'(raddr), 11);
    s_rst = 1; tick();
    chk("t6_rst_raddr", int'(raddr), 0);
    chk("t6_rst_dumping", int'(dumping), 0);
    chk("t6_rst_done", int'(capture_done), 0);
    chk("t6_rst_waddr", int'(waddr), 0);
    s_rst = 0;

    // clr_done beats a simultaneous dump_start.
    s_tp = 0; tick();
    s_wrt = 1; ticks(16); s_wrt = 0;
    s_trig = 1; tick(); s_trig = 0;
    s_clr = 1; s_ds = 1; tick(); s_clr = 0; s_ds = 0;
    tick();
    chk("t7_dumping", int'(dumping), 0);
    chk("t7_done", int'(capture_done), 0);

    // Randomized scenarios against the reference model.
    for (int sc = 0; sc < 30; sc++) begin
      clear_pulses(); s_run = 0; s_clr = 1; tick(); s_clr = 0;
      s_tp = (sc % 6 == 0) ? 0 : (sc % 6 == 1) ? D - 1 : int'($urandom_range(0, D - 1));
      for (int c = 0; c < 160; c++) begin
        s_run  = ($urandom_range(0, 199) == 0) ? 0 : 1;
        s_wrt  = ($urandom_range(0, 99) < 70) ? 1 : 0;
        s_trig = ($urandom_range(0, 99) < 15) ? 1 : 0;
        s_clr  = ($urandom_range(0, 99) < 2) ? 1 : 0;
        s_ds   = ($urandom_range(0, 99) < 10) ? 1 : 0;
        s_dn   = ($urandom_range(0, 99) < 60) ? 1 : 0;
        s_rst  = ($urandom_range(0, 299) == 0) ? 1 : 0;
        tick();
      end
    end

    clear_pulses(); s_run = 0;
    ticks(3);
    @(negedge clk);
    #1;
    chk("st_q_drained", st_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
